// File: rtl/xunit_sha_compress_if.sv
// Handshake and data bundle between a Versat controller and the SHA-256
// compression unit: run/done control, the W/K word stream, the delay and
// IV-reload configuration, and the eight exposed hash words.
interface xunit_sha_compress_if #(
  parameter int DATA_W = 32
);
  logic              run;
  logic              done;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [7:0]        configDelay;
  logic              configInit;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic [DATA_W-1:0] out3;
  logic [DATA_W-1:0] out4;
  logic [DATA_W-1:0] out5;
  logic [DATA_W-1:0] out6;
  logic [DATA_W-1:0] out7;

  modport master (
    output run, in0, in1, configDelay, configInit,
    input  done, out0, out1, out2, out3, out4, out5, out6, out7
  );

  modport slave (
    input  run, in0, in1, configDelay, configInit,
    output done, out0, out1, out2, out3, out4, out5, out6, out7
  );
endinterface

// File: rtl/xunit_sha_compress.sv
// SHA-256 compression unit. After a run pulse it waits configDelay cycles,
// performs 64 rounds consuming one W[t]/K[t] pair per cycle, then folds the
// working variables into the 256-bit hash state. Back-to-back runs with
// configInit = 0 chain blocks of a multi-block message.
module xunit_sha_compress #(
  parameter int DELAY_W = 10,
  parameter int DATA_W  = 32
) (
  input logic                  clk,
  input logic                  rst,
  xunit_sha_compress_if.slave  bus
);

  // Only the low 8 bits of the delay field are meaningful for this unit.
  localparam int CFG_DELAY_W = (DELAY_W > 8) ? 8 : DELAY_W;

  localparam logic [DATA_W-1:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ROUND = 2'd2,
    S_FINAL = 2'd3
  } state_t;

  state_t                 state;
  logic                   done_q;
  logic [CFG_DELAY_W-1:0] delay;
  logic [5:0]             round;
  logic [DATA_W-1:0]      hash [8];   // H0..H7
  logic [DATA_W-1:0]      wv   [8];   // working variables a..h

  logic [CFG_DELAY_W-1:0] cfg_delay;
  logic [DATA_W-1:0]      sum0, sum1, ch, maj, t1, t2;

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  assign cfg_delay = bus.configDelay[CFG_DELAY_W-1:0];

  // One SHA-256 round computed from the current working variables and W/K.
  always_comb begin
    // NOTE: every always_comb output is assigned on every path (here
    // unconditionally); a path that leaves one unassigned infers a latch.
    sum1 = rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25);
    ch   = (wv[4] & wv[5]) ^ (~wv[4] & wv[6]);
    sum0 = rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22);
    maj  = (wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]);
    t1   = wv[7] + sum1 + ch + bus.in1 + bus.in0;
    t2   = sum0 + maj;
  end

  // Control FSM plus hash/working-variable datapath; run overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      done_q <= 1'b1;
      delay  <= '0;
      round  <= '0;
      // NOTE: these arrays are flop banks, not RAM, so resetting every entry
      // is intended; a real memory would be left out of the reset.
      for (int i = 0; i < 8; i++) begin
        hash[i] <= IV[i];
        wv[i]   <= '0;
      end
    end else if (bus.run) begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values regardless of statement order.
      delay  <= cfg_delay;
      round  <= '0;
      done_q <= 1'b0;
      state  <= (cfg_delay != '0) ? S_WAIT : S_ROUND;
      for (int i = 0; i < 8; i++) begin
        wv[i] <= bus.configInit ? IV[i] : hash[i];
        if (bus.configInit) hash[i] <= IV[i];
      end
    end else begin
      case (state)
        S_WAIT: begin
          delay <= delay - 1'b1;
          if (delay == 1) state <= S_ROUND;
        end
        S_ROUND: begin
          wv[0] <= t1 + t2;
          wv[1] <= wv[0];
          wv[2] <= wv[1];
          wv[3] <= wv[2];
          wv[4] <= wv[3] + t1;
          wv[5] <= wv[4];
          wv[6] <= wv[5];
          wv[7] <= wv[6];
          round <= round + 1'b1;
          if (round == 6'd63) state <= S_FINAL;
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) hash[i] <= hash[i] + wv[i];
          state  <= S_IDLE;
          done_q <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.done = done_q;
  assign bus.out0 = hash[0];
  assign bus.out1 = hash[1];
  assign bus.out2 = hash[2];
  assign bus.out3 = hash[3];
  assign bus.out4 = hash[4];
  assign bus.out5 = hash[5];
  assign bus.out6 = hash[6];
  assign bus.out7 = hash[7];

endmodule

// File: tb/tb_xunit_sha_compress.sv
// Self-checking bench for xunit_sha_compress. The bench expands each 512-bit
// block into its message schedule, streams W/K into the unit, and pops the
// expected digest and latency from a scoreboard when done returns high.
module tb_xunit_sha_compress;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xunit_sha_compress_if #(.DATA_W(32)) bus ();

  xunit_sha_compress #(.DELAY_W(10), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam logic [255:0] IV_ALL =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] CHAIN_DIG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] M1_BLK = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M2_BLK = {{15{32'h0}}, 32'h000001c0};

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct packed {
    logic         chk_digest;
    logic [255:0] digest;
    logic [31:0]  latency;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] w_sched [64];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] outs();
    return {bus.out0, bus.out1, bus.out2, bus.out3,
            bus.out4, bus.out5, bus.out6, bus.out7};
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message-schedule expansion of one block (word 0 in the top bits).
  task automatic load_block(input logic [511:0] m);
    for (int t = 0; t < 16; t++) w_sched[t] = m[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w_sched[t] = (rr(w_sched[t-2], 17) ^ rr(w_sched[t-2], 19) ^ (w_sched[t-2] >> 10))
                 + w_sched[t-7]
                 + (rr(w_sched[t-15], 7) ^ rr(w_sched[t-15], 18) ^ (w_sched[t-15] >> 3))
                 + w_sched[t-16];
  endtask

  // Called at a negedge; the run is sampled at the following posedge.
  task automatic start_run(input logic init, input logic [7:0] delay);
    bus.run         = 1'b1;
    bus.configInit  = init;
    bus.configDelay = delay;
    bus.in0         = $urandom;
    bus.in1         = $urandom;
    @(negedge clk);
    bus.run         = 1'b0;
    bus.configInit  = ~init;
    bus.configDelay = 8'($urandom);
    check("done_fall", 256'(bus.done), 256'(0));
    if (init) check("iv_reload", outs(), IV_ALL);
  endtask

  // Drives delay filler words, then rounds 0..nrounds-1.
  task automatic stream(input int delay, input int nrounds);
    for (int i = 0; i < delay; i++) begin
      bus.in0 = 32'hffffffff;
      bus.in1 = 32'hffffffff;
      @(negedge clk);
    end
    for (int t = 0; t < nrounds; t++) begin
      bus.in0 = w_sched[t];
      bus.in1 = K_TAB[t];
      @(negedge clk);
    end
  endtask

  task automatic finish_block(input int delay, input logic chk_hold, input logic [255:0] h_hold);
    exp_t e;
    int   n;
    if (chk_hold) check("hold_until_final", outs(), h_hold);
    n = delay + 64;
    bus.in0 = $urandom;
    bus.in1 = $urandom;
    while (!bus.done && n < delay + 120) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      check("sb_underflow", 256'(1), 256'(0));
    end else begin
      e = sb.pop_front();
      check("latency", 256'(n), 256'(e.latency));
      if (e.chk_digest) check("digest", outs(), e.digest);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 1'b0;
    bus.configInit = 1'b0;
    bus.configDelay = 8'd0;
    bus.in0 = '0;
    bus.in1 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_done", 256'(bus.done), 256'(1));
    check("reset_iv", outs(), IV_ALL);
    rst = 1'b0;

    // Idle: random inputs must not disturb anything.
    for (int i = 0; i < 10; i++) begin
      bus.in0 = $urandom;
      bus.in1 = $urandom;
      @(negedge clk);
      check("idle_out", outs(), IV_ALL);
      check("idle_done", 256'(bus.done), 256'(1));
    end

    // "abc", no delay.
    load_block(ABC_BLK);
    sb.push_back('{1'b1, ABC_DIG, 32'd65});
    start_run(1'b1, 8'd0);
    stream(0, 64);
    finish_block(0, 1'b1, IV_ALL);

    // "abc" with 5 wait cycles of all-ones filler.
    sb.push_back('{1'b1, ABC_DIG, 32'd70});
    start_run(1'b1, 8'd5);
    stream(5, 64);
    finish_block(5, 1'b1, IV_ALL);

    // Two-block chaining; the second block also uses a short delay.
    load_block(M1_BLK);
    sb.push_back('{1'b0, 256'd0, 32'd65});
    start_run(1'b1, 8'd0);
    stream(0, 64);
    finish_block(0, 1'b1, IV_ALL);
    load_block(M2_BLK);
    sb.push_back('{1'b1, CHAIN_DIG, 32'd68});
    start_run(1'b0, 8'd3);
    stream(3, 64);
    finish_block(3, 1'b0, 256'd0);

    // Restart at round 30 of "abc".
    load_block(ABC_BLK);
    start_run(1'b1, 8'd0);
    stream(0, 30);
    sb.push_back('{1'b1, ABC_DIG, 32'd65});
    start_run(1'b1, 8'd0);
    stream(0, 64);
    finish_block(0, 1'b1, IV_ALL);

    // Chain from the abc digest, then reset at round 40: H must snap to IV.
    start_run(1'b0, 8'd0);
    stream(0, 40);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_done", 256'(bus.done), 256'(1));
    check("rst_mid_iv", outs(), IV_ALL);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // A normal "abc" run after the mid-block reset.
    sb.push_back('{1'b1, ABC_DIG, 32'd65});
    start_run(1'b1, 8'd0);
    stream(0, 64);
    finish_block(0, 1'b1, IV_ALL);

    check("sb_drained", 256'(sb.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
